usb_tx_arbiter: RTL
===================

Name: usb_tx_arbiter

Overview:
- Sequencer and arbiter in front of the USB TX byte interface (clk48 side of the serializer/bit-stuff/NRZI TX path).
- Shares the single transmitter between two requesters: a handshake responder (one-byte ACK/NAK/STALL packets) and an endpoint data source (PID + payload byte stream).
- Generates the send-request pulse, muxes the byte handshake, tracks packet completion through `sending`, and enforces an inter-packet gap.

Parameters:
- IPG_CYCLES, 8: clk48 cycles of idle enforced after `sending` falls before the next grant; 0 disables the gap.

Ports:
- clk48  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- hsReq  in  1  handshake requester wants to send; level, held until hsDone
- hsPID  in  4  handshake PID nibble; sampled when the grant is taken
- hsDone  out  1  one-cycle pulse: handshake packet fully transmitted
- dataReq  in  1  data requester wants to send; level, held until dataDone
- dataGrant  out  1  high while the data requester owns the byte interface
- dataAcceptNewData  out  1  data requester may present the next byte
- dataValid  in  1  data byte valid
- dataIsLastByte  in  1  data byte is the last of the packet
- data  in  8  data byte; first byte is the PID
- dataDone  out  1  one-cycle pulse: data packet fully transmitted
- txReqSendPacket  out  1  start-packet request to the transmitter
- txAcceptNewData  in  1  transmitter byte buffer empty
- txDataValid  out  1  byte valid to the transmitter
- txIsLastByte  out  1  last-byte flag to the transmitter
- txData  out  8  byte to the transmitter
- sending  in  1  transmitter is driving the line
- busy  out  1  any state other than IDLE

Behaviour:
- Reset values, applied asynchronously for any state including mid-packet: state=IDLE; all outputs 0; latched PID=0; seenSending=0; gap counter=0. RST cancels an in-flight packet; no done pulse is issued.
- States: IDLE, START, HS_BYTE, DATA_STREAM, WAIT_END, GAP.
- IDLE:
  - hsReq=1 → latch hsPID, owner=HS, go to START. Handshake has fixed priority: if both requests are high in the same cycle, HS wins.
  - else dataReq=1 → owner=DATA, go to START.
- START, exactly one cycle:
  - txReqSendPacket=1; seenSending cleared.
  - next state: HS_BYTE if owner=HS, DATA_STREAM if owner=DATA.
- HS_BYTE:
  - txData={~pid,pid}, txDataValid=1, txIsLastByte=1.
  - When txAcceptNewData=1 (transfer occurs this cycle) → WAIT_END.
- DATA_STREAM:
  - dataGrant=1; combinational pass-through: txData=data, txDataValid=dataValid, txIsLastByte=dataIsLastByte, dataAcceptNewData=txAcceptNewData.
  - When txAcceptNewData && dataValid && dataIsLastByte → WAIT_END.
  - dataReq dropping mid-stream is ignored; the requester must finish the packet.
- seenSending: set in any state after START whenever sending=1.
- WAIT_END:
  - All tx* outputs 0.
  - When seenSending=1 and sending=0: one-cycle hsDone or dataDone (per owner); go to GAP, or to IDLE if IPG_CYCLES=0.
- GAP:
  - Counter loads IPG_CYCLES-1 on entry and decrements.
  - At 0 → IDLE. The arbitration decision is taken in the IDLE cycle after the gap.
  - Requests raised during GAP stay pending (level semantics) and are not lost.
- dataAcceptNewData and dataGrant are 0 outside DATA_STREAM. tx* outputs are 0 outside START, HS_BYTE and DATA_STREAM, except txReqSendPacket, which is high only in START.
- Requesters must deassert req in the cycle after done. If req is still high, it re-arbitrates after the gap.
- Counter width is $clog2(IPG_CYCLES+1), minimum 1. No wrap: the counter stops at 0.

Test Plan:
- Single handshake, hsPID=4'h2 (ACK), IPG_CYCLES=8: START pulse 1 cycle; txData=8'hD2 with txIsLastByte=1 held until txAcceptNewData; model sending high 20 cycles → hsDone pulses 1 cycle after sending falls; busy falls exactly 8 cycles later.
- Data packet PID 8'hC3 plus 3 payload bytes 11,22,33 (last on 33), transmitter accepting every 8th cycle: bytes appear on txData in order, each accepted exactly once; dataDone after sending falls; dataGrant high only in DATA_STREAM.
- hsReq and dataReq asserted in the same cycle: handshake sent first; data starts in the IDLE cycle after its gap; both done pulses seen once each.
- hsReq raised during DATA_STREAM and during GAP: ignored until IDLE, then granted; no byte corruption of the active data packet.
- RST asserted mid DATA_STREAM after 2 bytes: all outputs 0 asynchronously; no dataDone; after release, a new dataReq runs a full packet normally.
- IPG_CYCLES=0 with back-to-back hsReq held high: second START occurs in the cycle after the IDLE return following hsDone.

Source files
------------

// File: rtl/usb_tx_arbiter_if.sv
// Byte handshake bundle between the TX arbiter, its two requesters and the USB transmitter.
// master = arbiter side, slave = requesters/transmitter side.
interface usb_tx_arbiter_if;
  logic       hsReq;
  logic [3:0] hsPID;
  logic       hsDone;
  logic       dataReq;
  logic       dataGrant;
  logic       dataAcceptNewData;
  logic       dataValid;
  logic       dataIsLastByte;
  logic [7:0] data;
  logic       dataDone;
  logic       txReqSendPacket;
  logic       txAcceptNewData;
  logic       txDataValid;
  logic       txIsLastByte;
  logic [7:0] txData;
  logic       sending;
  logic       busy;

  modport master (
    input  hsReq, hsPID, dataReq, dataValid, dataIsLastByte, data, txAcceptNewData, sending,
    output hsDone, dataGrant, dataAcceptNewData, dataDone, txReqSendPacket, txDataValid,
           txIsLastByte, txData, busy
  );

  modport slave (
    output hsReq, hsPID, dataReq, dataValid, dataIsLastByte, data, txAcceptNewData, sending,
    input  hsDone, dataGrant, dataAcceptNewData, dataDone, txReqSendPacket, txDataValid,
           txIsLastByte, txData, busy
  );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Shares the USB TX byte interface between a handshake responder and an endpoint data source,
// sequencing start request, byte transfer, end-of-packet detection and inter-packet gap.
module usb_tx_arbiter #(
  parameter int unsigned IPG_CYCLES = 8
) (
  input  logic             clk48,
  input  logic             RST,
  usb_tx_arbiter_if.master bus
);

  localparam int unsigned GAP_W    = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;
  localparam int unsigned GAP_LOAD = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HS_BYTE,
    ST_DATA_STREAM,
    ST_WAIT_END,
    ST_GAP
  } state_e;

  state_e           state_q;
  logic             owner_hs_q;
  logic [3:0]       pid_q;
  logic             seen_q;
  logic [GAP_W-1:0] gap_q;
  logic             req_q;
  logic             hs_valid_q;
  logic             grant_q;
  logic             hs_done_q;
  logic             data_done_q;
  logic             busy_q;

  always_ff @(posedge clk48 or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      owner_hs_q  <= 1'b0;
      pid_q       <= 4'h0;
      seen_q      <= 1'b0;
      gap_q       <= '0;
      req_q       <= 1'b0;
      hs_valid_q  <= 1'b0;
      grant_q     <= 1'b0;
      hs_done_q   <= 1'b0;
      data_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_q       <= 1'b0;
      hs_done_q   <= 1'b0;
      data_done_q <= 1'b0;

      // Line activity is only meaningful once the start request has been issued.
      if ((state_q == ST_HS_BYTE || state_q == ST_DATA_STREAM || state_q == ST_WAIT_END) &&
          bus.sending) begin
        seen_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.hsReq) begin
            pid_q      <= bus.hsPID;
            owner_hs_q <= 1'b1;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end else if (bus.dataReq) begin
            owner_hs_q <= 1'b0;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end

        ST_START: begin
          seen_q <= 1'b0;
          if (owner_hs_q) begin
            hs_valid_q <= 1'b1;
            state_q    <= ST_HS_BYTE;
          end else begin
            grant_q <= 1'b1;
            state_q <= ST_DATA_STREAM;
          end
        end

        ST_HS_BYTE: begin
          if (bus.txAcceptNewData) begin
            hs_valid_q <= 1'b0;
            state_q    <= ST_WAIT_END;
          end
        end

        // A dropped dataReq is ignored here; the source must finish its packet.
        ST_DATA_STREAM: begin
          if (bus.txAcceptNewData && bus.dataValid && bus.dataIsLastByte) begin
            grant_q <= 1'b0;
            state_q <= ST_WAIT_END;
          end
        end

        ST_WAIT_END: begin
          if (seen_q && !bus.sending) begin
            hs_done_q   <= owner_hs_q;
            data_done_q <= ~owner_hs_q;
            if (IPG_CYCLES == 0) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              gap_q   <= GAP_W'(GAP_LOAD);
              state_q <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Data bytes pass straight through while granted; the handshake byte comes from the latched PID.
  assign bus.txReqSendPacket   = req_q;
  assign bus.dataGrant         = grant_q;
  assign bus.dataAcceptNewData = grant_q & bus.txAcceptNewData;
  assign bus.txDataValid       = grant_q ? bus.dataValid      : hs_valid_q;
  assign bus.txIsLastByte      = grant_q ? bus.dataIsLastByte : hs_valid_q;
  assign bus.txData            = grant_q ? bus.data : (hs_valid_q ? {~pid_q, pid_q} : 8'h00);
  assign bus.hsDone            = hs_done_q;
  assign bus.dataDone          = data_done_q;
  assign bus.busy              = busy_q;

endmodule
